// File: rtl/lfsr_box_picker.sv
// rtl/lfsr_box_picker.sv - uniform 1..NUM_BOXES box draw by rejection sampling a free-running Fibonacci LFSR
// Optional feature macro: LFSR_NO_REPEAT_EN (consecutive boxes always differ).
module lfsr_box_picker #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(8'hB8),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
  parameter int               NUM_BOXES = 4,
  parameter int               BOX_W     = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic [BOX_W-1:0] box,
  output logic             box_valid,
  output logic             busy,
  output logic [WIDTH-1:0] lfsr_state
);

  localparam int CAND_W = $clog2(NUM_BOXES);
  localparam logic [CAND_W:0] NB_CMP = (CAND_W + 1)'(NUM_BOXES);

  typedef enum logic {IDLE, DRAW} state_t;

  state_t            state;
  logic [WIDTH-1:0]  lfsr;
  logic [WIDTH-1:0]  try_cnt;
  logic [CAND_W-1:0] cand;
  logic [BOX_W-1:0]  cand_box;
  logic [BOX_W-1:0]  wrap_box;
  logic              feedback;
  logic              in_range;
  logic              accept;
  logic              fallback;

  assign feedback   = ^(lfsr & TAPS);
  assign cand       = lfsr[CAND_W-1:0];
  assign cand_box   = BOX_W'(cand) + BOX_W'(1);
  assign in_range   = {1'b0, cand} < NB_CMP;
  assign lfsr_state = lfsr;

`ifdef LFSR_NO_REPEAT_EN
  // box==0 never matches cand_box, so the very first draw is unrestricted
  assign accept = in_range && (cand_box != box);
`else
  assign accept = in_range;
`endif

  // Escape hatch after a full LFSR period of rejections; always differs from the current box
  assign fallback = &try_cnt;
  assign wrap_box = (box == BOX_W'(NUM_BOXES)) ? BOX_W'(1) : box + BOX_W'(1);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      lfsr      <= SEED;
      state     <= IDLE;
      try_cnt   <= '0;
      box       <= '0;
      box_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if (seed_load)
        lfsr <= (seed_in == '0) ? SEED : seed_in;
      else
        lfsr <= {lfsr[WIDTH-2:0], feedback};

      box_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            state   <= DRAW;
            busy    <= 1'b1;
            try_cnt <= '0;
          end
        end
        DRAW: begin
          if (fallback) begin
            box       <= wrap_box;
            box_valid <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else if (accept) begin
            box       <= cand_box;
            box_valid <= 1'b1;
            state     <= IDLE;
            busy      <= 1'b0;
          end else begin
            try_cnt <= try_cnt + WIDTH'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_box_picker.sv
// tb/tb_lfsr_box_picker.sv - self-checking bench for lfsr_box_picker (default and NUM_BOXES=5 instances)
module tb_lfsr_box_picker;

  localparam int         WIDTH  = 8;
  localparam logic [7:0] TAPS   = 8'hB8;
  localparam logic [7:0] SEED   = 8'h01;
  localparam int         NB     = 4;
  localparam int         CAND_W = $clog2(NB);

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1, seed_load = 1'b0, req = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic [3:0] box;
  logic       box_valid, busy;
  logic [7:0] lfsr_state;

  logic       reset5 = 1'b1, seed_load5 = 1'b0, req5 = 1'b0;
  logic [7:0] seed_in5 = 8'h00;
  logic [3:0] box5;
  logic       box_valid5, busy5;
  logic [7:0] lfsr_state5;

  always #10 CLOCK_50 = ~CLOCK_50;

  lfsr_box_picker #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .NUM_BOXES(4), .BOX_W(4)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .seed_load(seed_load), .seed_in(seed_in), .req(req),
    .box(box), .box_valid(box_valid), .busy(busy), .lfsr_state(lfsr_state)
  );

  lfsr_box_picker #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .NUM_BOXES(5), .BOX_W(4)) dut5 (
    .CLOCK_50(CLOCK_50), .reset(reset5), .seed_load(seed_load5), .seed_in(seed_in5), .req(req5),
    .box(box5), .box_valid(box_valid5), .busy(busy5), .lfsr_state(lfsr_state5)
  );

  int         n_tests = 0;
  int         n_fail = 0;
  logic [7:0] m_lfsr = SEED;
  int         m_box = 0;

  typedef struct {
    logic       rst;
    logic       sl;
    logic [7:0] si;
    logic       rq;
    logic [7:0] e_lfsr;
    logic [3:0] e_box;
    logic       e_valid;
    logic       e_busy;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Next LFSR value from the shift-and-parity rule, in plain arithmetic
  function automatic logic [7:0] nxt(input logic [7:0] x);
    int v;
    v = (int'(x) * 2) % 256 + ($countones(x & TAPS) % 2);
    return 8'(v);
  endfunction

  function automatic logic accept_m(input logic [7:0] v, input int last);
    int c;
    logic ok;
    c  = int'(v) % (1 << CAND_W);
    ok = (c < NB);
`ifdef LFSR_NO_REPEAT_EN
    if (c + 1 == last) ok = 1'b0;
`endif
    return ok;
  endfunction

  task automatic tick();
    if (reset) m_lfsr = SEED;
    else if (seed_load) m_lfsr = (seed_in == 8'h00) ? SEED : seed_in;
    else m_lfsr = nxt(m_lfsr);
    @(posedge CLOCK_50);
    #1;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         k, lat, exp_lat, exp_box, gap, pulses, bad, alt_bad, prev;
    logic       got, zero_seen, early;
    logic [7:0] v;
    logic [3:0] seen;

    vecs[0]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 4'd0, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h04, 4'd3, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h08, 4'd3, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h11, 4'd3, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h23, 4'd3, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h47, 4'd3, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 8'h00, 1'b0, 8'h01, 4'd3, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 4'd3, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 4'd3, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 4'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 8'h02, 4'd0, 1'b0, 1'b0};

    // Reset state
    tick();
    tick();
    chk("rst_lfsr", lfsr_state, 8'h01);
    chk("rst_box", box, 0);
    chk("rst_valid", box_valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;

    // Directed vectors: sequence, first draw, zero seed, reset mid-draw
    for (int i = 0; i < 11; i++) begin
      reset = vecs[i].rst; seed_load = vecs[i].sl; seed_in = vecs[i].si; req = vecs[i].rq;
      tick();
      chk($sformatf("vec%0d_lfsr", i), lfsr_state, vecs[i].e_lfsr);
      chk($sformatf("vec%0d_box", i), box, vecs[i].e_box);
      chk($sformatf("vec%0d_valid", i), box_valid, vecs[i].e_valid);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
    end
    reset = 1'b0; seed_load = 1'b0; req = 1'b0;
    m_box = 0;

    // LFSR period 255, never zero
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("period_start", lfsr_state, 8'h01);
    zero_seen = 1'b0; early = 1'b0;
    for (int i = 1; i <= 255; i++) begin
      tick();
      if (lfsr_state == 8'h00) zero_seen = 1'b1;
      if (lfsr_state == 8'h01 && i < 255) early = 1'b1;
    end
    chk("period_end", lfsr_state, 8'h01);
    chk("period_zero", zero_seen, 0);
    chk("period_early", early, 0);

    // NUM_BOXES=5: three rejections then box 3
    reset5 = 1'b0;
    tick();
    seed_load5 = 1'b1; seed_in5 = 8'h07; req5 = 1'b1;
    tick();
    seed_load5 = 1'b0; req5 = 1'b0;
    chk("n5_lfsr_seeded", lfsr_state5, 8'h07);
    chk("n5_busy_start", busy5, 1);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk($sformatf("n5_valid_%0d", i), box_valid5, (i == 4));
      chk($sformatf("n5_busy_%0d", i), busy5, (i < 4));
    end
    chk("n5_box", box5, 3);

    // Repeat rule: box 3, then force candidate 2 with a seed load
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("rep_first_valid", box_valid, 1);
    chk("rep_first_box", box, 3);
    seed_load = 1'b1; seed_in = 8'h02; req = 1'b1;
    tick();
    seed_load = 1'b0; req = 1'b0;
`ifdef LFSR_NO_REPEAT_EN
    exp_lat = 2; exp_box = 1;
`else
    exp_lat = 1; exp_box = 3;
`endif
    lat = 0; got = 1'b0;
    while (!got && lat < 8) begin
      tick();
      lat++;
      if (box_valid) got = 1'b1;
    end
    chk("rep_latency", lat, exp_lat);
    chk("rep_box", box, exp_box);
    m_box = exp_box;

`ifndef LFSR_NO_REPEAT_EN
    // Held req: one box every 2 cycles, all values seen
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 1'b1;
    pulses = 0; bad = 0; alt_bad = 0; seen = 4'b0000;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (box_valid != (i % 2 == 0)) alt_bad++;
      if (box_valid) begin
        pulses++;
        if (box < 1 || box > 4) bad++;
        else seen[box - 1] = 1'b1;
      end
    end
    req = 1'b0;
    chk("held_pulses", pulses, 100);
    chk("held_alternate", alt_bad, 0);
    chk("held_range", bad, 0);
    chk("held_all_seen", seen, 4'b1111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_box = 0;
`endif

    // Randomised draws against the model
    for (int d = 0; d < 1000; d++) begin
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      seed_load = 1'($urandom_range(0, 1));
      seed_in = 8'($urandom);
      req = 1'b1;
      tick();
      seed_load = 1'b0; req = 1'b0;
      v = m_lfsr; k = 0;
      while (!accept_m(v, m_box) && k < 300) begin
        v = nxt(v);
        k++;
      end
      exp_box = int'(v) % (1 << CAND_W) + 1;
      lat = 0; got = 1'b0;
      while (!got && lat < k + 6) begin
        tick();
        lat++;
        if (box_valid) got = 1'b1;
      end
      prev = m_box;
      chk($sformatf("rnd%0d_latency", d), lat, k + 1);
      chk($sformatf("rnd%0d_box", d), box, exp_box);
      chk($sformatf("rnd%0d_lfsr", d), lfsr_state, m_lfsr);
`ifdef LFSR_NO_REPEAT_EN
      chk($sformatf("rnd%0d_norepeat", d), (int'(box) != prev), 1);
`endif
      m_box = exp_box;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_box_picker.md
# lfsr_box_picker

Parametrised random box selector for the whack-a-mole game logic. It is the next generation of the fixed 3-bit LFSR-to-box mapper. A configurable-width Fibonacci LFSR runs freely every clock. On request, the block draws a uniformly distributed box number 1..NUM_BOXES by rejection sampling, with run-time reseeding and an optional no-immediate-repeat rule. It sits between the game-control FSM (which issues `req`) and the box/LED/HEX display logic (which consumes `box`).

## Interface
- WIDTH, 8: LFSR width, 4..16; must exceed CAND_W.
- TAPS, 8'hB8: feedback mask; bit i set means lfsr[i] feeds the XOR. Must be maximal-length for WIDTH.
- SEED, 1: reset and fallback seed; must be nonzero.
- NUM_BOXES, 4: number of boxes, 2..15.
- BOX_W, 4: width of `box`; must satisfy 2^BOX_W > NUM_BOXES.
- CAND_W (localparam): $clog2(NUM_BOXES).

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- seed_load  in  1  load seed_in into the LFSR at this edge.
- seed_in  in  WIDTH  new seed; 0 is replaced by SEED.
- req  in  1  request one draw; sampled only in IDLE.
- box  out  BOX_W  last drawn box, 1..NUM_BOXES; 0 until the first draw.
- box_valid  out  1  one-cycle pulse when `box` updates.
- busy  out  1  high while a draw is in progress (state DRAW).
- lfsr_state  out  WIDTH  current LFSR register (debug/test).

## Operation
- LFSR update when not in reset and seed_load=0: lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}. It steps every cycle regardless of FSM state.
- seed_load=1: lfsr <= (seed_in==0 ? SEED : seed_in). This replaces the step for that edge.
- FSM states:
  - IDLE: req=1 goes to DRAW and clears the try counter.
  - DRAW: evaluates cand = lfsr[CAND_W-1:0] each cycle.
  - Accept if cand < NUM_BOXES (plus the repeat rule; see Configuration). On accept: box <= cand+1, box_valid <= 1, last box updated, go to IDLE.
  - Reject: stay in DRAW and increment the try counter (WIDTH bits).
  - Fallback: if the try counter reaches 2^WIDTH-1 rejections, the next DRAW cycle accepts unconditionally. The fallback value is box <= (box mod NUM_BOXES)+1.
- req while busy is ignored, not queued.
- If NUM_BOXES is a power of two, every candidate is in range, so only the repeat rule can reject.
- seed_load during DRAW is legal. The draw continues and evaluates the newly loaded value on the next cycle.
- Reset (highest priority) sets: lfsr=SEED, box=0, box_valid=0, busy=0, state IDLE, try counter 0. Reset mid-draw abandons the draw with no box_valid pulse.

## Timing
- All outputs are registered. lfsr_state is the register itself.
- If req is sampled at edge t, DRAW first evaluates lfsr during the cycle after t. Best case, box/box_valid update at edge t+1; each rejection adds one cycle.
- box_valid is high for exactly one cycle. The state is IDLE in that cycle, so a held req starts the next draw at the same edge box_valid falls. Maximum rate is one box every 2 cycles.
- busy = (state==DRAW), registered alongside the state.
- box holds its value between draws.

## Configuration
- LFSR_NO_REPEAT_EN defined: DRAW additionally rejects cand+1 == current box, so consecutive boxes always differ. Fallback already guarantees a different box. With box==0 (no draw yet), nothing is excluded.
- Undefined: repeats are allowed; acceptance is only cand < NUM_BOXES.

## Test plan
- Defaults, reset released, no seed_load: lfsr_state reads 0x01, 0x02, 0x04, 0x08, 0x11, 0x23, 0x47 on consecutive cycles. It returns to 0x01 after exactly 255 steps and never reads 0x00.
- Defaults, req=1 for one cycle at the first edge after reset release: DRAW sees 0x02, so box=3 with a one-cycle box_valid at the following edge. busy is high for one cycle.
- NUM_BOXES=5, BOX_W=4: seed_load=1, seed_in=0x07 and req=1 at the same edge. Candidates 7 (0x07), 6 (0x0E) and 5 (0x1D) are rejected, and 0x3A is accepted. Expect box=3 with box_valid 4 edges later and busy high for 4 cycles.
- seed_load=1 with seed_in=0x00: lfsr_state=0x01 next cycle, then 0x02. Asserting reset during DRAW: no box_valid pulse, box=0, busy=0.
- LFSR_NO_REPEAT_EN, defaults: after a draw producing box=3, force the next DRAW to see lfsr low bits=2 via seed_load 0x02 with req. That candidate is rejected and the next candidate (0x04, so box 1) is accepted. Over 1000 draws, no two consecutive boxes are equal.
- Held req=1 for 200 cycles, macro undefined: box_valid pulses every 2 cycles and all box values are in 1..4. Each value appears at least once and req is never lost.
